multi_lane_acc_buffer: RTL and testbench

- Next-generation output accumulation buffer for the compute-unit top level.
- Accepts partial sums from NUM_LANES compute units in parallel. Each lane targets any of BUF_NUM entries, and several lanes may hit the same entry in one cycle.
- Applies signed saturating or wrapping arithmetic.
- Provides a valid/ready drain engine that streams all entries out, optionally clearing each entry as it is read.

---
 rtl/multi_lane_acc_buffer.sv | 173 +++++++++++++++++
 tb/tb_multi_lane_acc_buffer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_lane_acc_buffer.sv
// multi_lane_acc_buffer: multi-port signed accumulation buffer with a
// valid/ready drain engine that streams every entry out, optionally clearing.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   clr_i               synchronous clear of entries, overflow flag and drain
//   acc_val_i           per-lane accumulate request
//   acc_sel_i           per-lane entry index (lane k in slice k)
//   acc_dat_i           per-lane signed partial sum (lane k in slice k)
//   acc_ready_o         accumulates accepted (FSM idle)
//   drain_start_i       start streaming all entries
//   drain_clear_i       zero each entry as it is handshaken
//   drain_busy_o        drain in progress
//   drain_done_o        one-cycle pulse after the last entry
//   out_valid_o/ready_i output handshake
//   out_idx_o/out_dat_o presented entry index and value
//   ovf_o               sticky overflow flag
module multi_lane_acc_buffer #(
    parameter int NUM_LANES = 4,
    parameter int IN_SIZE   = 24,
    parameter int BUF_SIZE  = 32,
    parameter int BUF_NUM   = 32,
    parameter int SATURATE  = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clr_i,
    input  logic [NUM_LANES-1:0]           acc_val_i,
    input  logic [NUM_LANES*$clog2(BUF_NUM)-1:0] acc_sel_i,
    input  logic [NUM_LANES*IN_SIZE-1:0]   acc_dat_i,
    output logic                           acc_ready_o,
    input  logic                           drain_start_i,
    input  logic                           drain_clear_i,
    output logic                           drain_busy_o,
    output logic                           drain_done_o,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [$clog2(BUF_NUM)-1:0]     out_idx_o,
    output logic [BUF_SIZE-1:0]            out_dat_o,
    output logic                           ovf_o
);

    localparam int IDX_W = $clog2(BUF_NUM);
    localparam int SUM_W = BUF_SIZE + $clog2(NUM_LANES + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                clrf_q, clrf_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic [BUF_SIZE-1:0] mem_q [BUF_NUM];
    logic [BUF_SIZE-1:0] mem_d [BUF_NUM];

    logic                acc_rdy;
    logic [BUF_SIZE-1:0] acc_res [BUF_NUM];
    logic [BUF_NUM-1:0]  acc_ovf;

    assign acc_rdy = (state_q == S_IDLE);

    // Per-entry adder tree: the entry plus every accepted lane aimed at it,
    // summed wide enough that NUM_LANES+1 operands can never wrap.
    for (genvar e = 0; e < BUF_NUM; e++) begin : g_ent
        logic [SUM_W-1:0]          sum;
        logic [SUM_W-BUF_SIZE:0]   top;

        always_comb begin
            sum = {{(SUM_W-BUF_SIZE){mem_q[e][BUF_SIZE-1]}}, mem_q[e]};
            for (int k = 0; k < NUM_LANES; k++) begin
                if (acc_val_i[k] && acc_rdy &&
                    acc_sel_i[k*IDX_W +: IDX_W] == IDX_W'(e)) begin
                    sum = sum + {{(SUM_W-IN_SIZE){acc_dat_i[k*IN_SIZE+IN_SIZE-1]}},
                                 acc_dat_i[k*IN_SIZE +: IN_SIZE]};
                end
            end
        end

        // The result fits only if all bits from the BUF_SIZE sign bit up
        // are copies of each other.
        assign top        = sum[SUM_W-1:BUF_SIZE-1];
        assign acc_ovf[e] = ~((&top) | ~(|top));

        if (SATURATE != 0) begin : g_sat
            always_comb begin
                acc_res[e] = sum[BUF_SIZE-1:0];
                if (acc_ovf[e]) begin
                    acc_res[e] = sum[SUM_W-1] ? {1'b1, {(BUF_SIZE-1){1'b0}}}
                                              : {1'b0, {(BUF_SIZE-1){1'b1}}};
                end
            end
        end else begin : g_wrap
            assign acc_res[e] = sum[BUF_SIZE-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        clrf_d  = clrf_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        for (int e = 0; e < BUF_NUM; e++) begin
            mem_d[e] = mem_q[e];
        end

        if (clr_i) begin
            state_d = S_IDLE;
            idx_d   = '0;
            clrf_d  = 1'b0;
            ovf_d   = 1'b0;
            for (int e = 0; e < BUF_NUM; e++) begin
                mem_d[e] = '0;
            end
        end else if (state_q == S_IDLE) begin
            // Accumulates land in the same cycle a drain starts, so the
            // drain streams the updated values.
            for (int e = 0; e < BUF_NUM; e++) begin
                mem_d[e] = acc_res[e];
            end
            ovf_d = ovf_q | (|acc_ovf);
            if (drain_start_i) begin
                state_d = S_DRAIN;
                idx_d   = '0;
                clrf_d  = drain_clear_i;
            end
        end else begin
            if (out_ready_i) begin
                if (clrf_q) begin
                    mem_d[idx_q] = '0;
                end
                // Index wraps back to 0 since BUF_NUM is a power of two.
                idx_d = idx_q + 1'b1;
                if (&idx_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            clrf_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            for (int e = 0; e < BUF_NUM; e++) begin
                mem_q[e] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            clrf_q  <= clrf_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            for (int e = 0; e < BUF_NUM; e++) begin
                mem_q[e] <= mem_d[e];
            end
        end
    end

    assign acc_ready_o  = acc_rdy;
    assign drain_busy_o = (state_q == S_DRAIN);
    assign out_valid_o  = (state_q == S_DRAIN);
    assign drain_done_o = done_q;
    assign out_idx_o    = idx_q;
    assign out_dat_o    = mem_q[idx_q];
    assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_multi_lane_acc_buffer.sv
// tb_multi_lane_acc_buffer: directed scoreboard bench for the accumulation
// buffer; a saturating and a wrapping instance share the same stimulus.
module tb_multi_lane_acc_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [3:0]  acc_val;
    logic [11:0] acc_sel;
    logic [63:0] acc_dat;
    logic        drain_start;
    logic        drain_clear;
    logic        out_ready;

    logic        acc_ready_a, busy_a, done_a, valid_a, ovf_a;
    logic [2:0]  idx_a;
    logic [15:0] dat_a;
    logic        acc_ready_b, busy_b, done_b, valid_b, ovf_b;
    logic [2:0]  idx_b;
    logic [15:0] dat_b;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    int q_idx[$];
    int q_a[$];
    int q_b[$];

    always #5 clk = ~clk;

    multi_lane_acc_buffer #(
        .NUM_LANES(4), .IN_SIZE(16), .BUF_SIZE(16), .BUF_NUM(8), .SATURATE(1)
    ) u_sat (
        .clk_i(clk), .rst_i(rst), .clr_i(clr),
        .acc_val_i(acc_val), .acc_sel_i(acc_sel), .acc_dat_i(acc_dat),
        .acc_ready_o(acc_ready_a),
        .drain_start_i(drain_start), .drain_clear_i(drain_clear),
        .drain_busy_o(busy_a), .drain_done_o(done_a),
        .out_valid_o(valid_a), .out_ready_i(out_ready),
        .out_idx_o(idx_a), .out_dat_o(dat_a), .ovf_o(ovf_a)
    );

    multi_lane_acc_buffer #(
        .NUM_LANES(4), .IN_SIZE(16), .BUF_SIZE(16), .BUF_NUM(8), .SATURATE(0)
    ) u_wrap (
        .clk_i(clk), .rst_i(rst), .clr_i(clr),
        .acc_val_i(acc_val), .acc_sel_i(acc_sel), .acc_dat_i(acc_dat),
        .acc_ready_o(acc_ready_b),
        .drain_start_i(drain_start), .drain_clear_i(drain_clear),
        .drain_busy_o(busy_b), .drain_done_o(done_b),
        .out_valid_o(valid_b), .out_ready_i(out_ready),
        .out_idx_o(idx_b), .out_dat_o(dat_b), .ovf_o(ovf_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: samples mid-cycle after stimulus settles, checks handshakes
    // against the queues, stall stability and acc_ready during drain.
    initial begin
        bit       prev_stall = 0;
        int       prev_idx = 0;
        int       prev_dat = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 0;
                continue;
            end
            if (done_a) done_cnt++;
            if (valid_a) begin
                chk("acc_ready_in_drain", int'(acc_ready_a), 0);
                chk("busy_in_drain", int'(busy_a), 1);
            end
            if (prev_stall && valid_a) begin
                chk("stall_idx_hold", int'(idx_a), prev_idx);
                chk("stall_dat_hold", int'($signed(dat_a)), prev_dat);
            end
            if (valid_a && out_ready) begin
                if (q_idx.size() == 0) begin
                    chk("unexpected_output", int'(idx_a), -1);
                end else begin
                    chk("out_idx", int'(idx_a), q_idx.pop_front());
                    chk("out_dat_sat", int'($signed(dat_a)), q_a.pop_front());
                    chk("out_dat_wrap", int'($signed(dat_b)), q_b.pop_front());
                end
            end
            prev_stall = valid_a && !out_ready;
            prev_idx   = int'(idx_a);
            prev_dat   = int'($signed(dat_a));
        end
    end

    // Entered and left at a falling edge; one accepted cycle.
    task automatic acc_cycle(input logic [3:0] v, input logic [11:0] s,
                             input logic [63:0] d);
        acc_val = v;
        acc_sel = s;
        acc_dat = d;
        @(negedge clk);
        acc_val = '0;
    endtask

    task automatic drain(input bit clear, input bit rnd, input bit noise,
                         input logic [3:0] sv, input logic [11:0] ssel,
                         input logic [63:0] sdat,
                         input int ea[8], input int eb[8]);
        int d0;
        int cyc;
        for (int i = 0; i < 8; i++) begin
            q_idx.push_back(i);
            q_a.push_back(ea[i]);
            q_b.push_back(eb[i]);
        end
        d0 = done_cnt;
        drain_start = 1'b1;
        drain_clear = clear;
        acc_val = sv;
        acc_sel = ssel;
        acc_dat = sdat;
        @(negedge clk);
        drain_start = 1'b0;
        drain_clear = 1'b0;
        acc_val = '0;
        cyc = 0;
        while (done_cnt == d0 && cyc < 300) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (noise && cyc < 4) begin
                acc_val = 4'b0001;
                acc_sel = 12'd7;
                acc_dat = 64'd1000;
            end else begin
                acc_val = '0;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        acc_val = '0;
        chk("drain_timeout", int'(cyc < 300), 1);
        repeat (3) @(negedge clk);
        chk("done_pulses", done_cnt - d0, 1);
        chk("valid_after_drain", int'(valid_a), 0);
        chk("acc_ready_after_drain", int'(acc_ready_a), 1);
        chk("queue_empty", q_idx.size(), 0);
        q_idx.delete();
        q_a.delete();
        q_b.delete();
    endtask

    initial begin
        int z8[8];
        int ea[8];
        int eb[8];
        int d0;
        int cyc;
        z8 = '{default: 0};
        rst = 1'b1;
        clr = 1'b0;
        acc_val = '0;
        acc_sel = '0;
        acc_dat = '0;
        drain_start = 1'b0;
        drain_clear = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", int'(valid_a), 0);
        chk("rst_idx", int'(idx_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_ovf", int'(ovf_a), 0);
        chk("rst_acc_ready", int'(acc_ready_a), 1);
        @(negedge clk);

        // Single lane x3 into entry 3, then four-lane collision on entry 2.
        acc_cycle(4'b0001, 12'd3, 64'd5);
        acc_cycle(4'b0001, 12'd3, 64'd5);
        acc_cycle(4'b0001, 12'd3, 64'd5);
        acc_cycle(4'b1111, {4{3'd2}}, {16'd1, 16'd7, 16'hFFE2, 16'd100});
        chk("ovf_after_collision", int'(ovf_a), 0);

        // Clearing drain under random backpressure; lane noise is ignored.
        ea = '{0, 0, 78, 15, 0, 0, 0, 0};
        drain(1'b1, 1'b1, 1'b1, 4'd0, 12'd0, 64'd0, ea, ea);
        drain(1'b0, 1'b1, 1'b0, 4'd0, 12'd0, 64'd0, z8, z8);

        // Positive and negative overflow.
        acc_cycle(4'b0011, {3'd0, 3'd0, 3'd1, 3'd0},
                  {32'd0, 16'h8300, 16'd32000});
        chk("ovf_after_preload", int'(ovf_a), 0);
        acc_cycle(4'b1111, {3'd1, 3'd1, 3'd0, 3'd0},
                  {16'hFE0C, 16'hFE0C, 16'd500, 16'd500});
        chk("ovf_sat", int'(ovf_a), 1);
        chk("ovf_wrap", int'(ovf_b), 1);
        ea = '{32767, -32768, 0, 0, 0, 0, 0, 0};
        eb = '{-32536, 32536, 0, 0, 0, 0, 0, 0};
        drain(1'b1, 1'b0, 1'b0, 4'd0, 12'd0, 64'd0, ea, eb);
        chk("ovf_sticky", int'(ovf_a), 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("ovf_clr_sat", int'(ovf_a), 0);
        chk("ovf_clr_wrap", int'(ovf_b), 0);

        // clr_i at index 4 aborts the drain; a concurrent start is ignored.
        acc_cycle(4'b0001, 12'd5, 64'd9);
        for (int i = 0; i < 4; i++) begin
            q_idx.push_back(i);
            q_a.push_back(0);
            q_b.push_back(0);
        end
        d0 = done_cnt;
        drain_start = 1'b1;
        @(negedge clk);
        drain_start = 1'b0;
        cyc = 0;
        while (idx_a != 3'd4 && cyc < 50) begin
            out_ready = 1'b1;
            @(negedge clk);
            cyc++;
        end
        chk("reach_idx4", int'(idx_a), 4);
        out_ready = 1'b0;
        clr = 1'b1;
        drain_start = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        drain_start = 1'b0;
        chk("clr_valid", int'(valid_a), 0);
        chk("clr_busy", int'(busy_a), 0);
        chk("clr_idx", int'(idx_a), 0);
        repeat (3) @(negedge clk);
        chk("clr_no_done", done_cnt - d0, 0);
        chk("clr_queue_empty", q_idx.size(), 0);
        drain(1'b1, 1'b0, 1'b0, 4'd0, 12'd0, 64'd0, z8, z8);

        // Asynchronous reset between edges mid-drain.
        acc_cycle(4'b0001, 12'd6, 64'd42);
        d0 = done_cnt;
        drain_start = 1'b1;
        @(negedge clk);
        drain_start = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", int'(valid_a), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", int'(valid_a), 0);
        chk("arst_busy", int'(busy_a), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_acc_ready", int'(acc_ready_a), 1);
        chk("arst_idx", int'(idx_a), 0);
        @(negedge clk);
        repeat (2) @(negedge clk);
        chk("arst_no_done", done_cnt - d0, 0);

        // Accumulate in the same cycle as drain start is seen by the drain.
        ea = '{0, 0, 0, 0, 11, 0, 0, 0};
        drain(1'b0, 1'b1, 1'b0, 4'b0001, 12'd4, 64'd11, ea, ea);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
